wbp2classic: RTL and testbench

- Wishbone pipelined-slave to Wishbone classic-master bridge, the inverse of the existing classic-to-pipeline bridge.
- Sits downstream of a pipelined interconnect and drives a legacy classic-only peripheral.
- Accepts one pipelined request at a time, replays it as a registered classic cycle, and returns ack/err/data to the pipelined side.
- Supports bus abort and error recovery; an optional watchdog converts hung classic cycles into bus errors.

---
 rtl/wbp2classic.sv | 151 +++++++++++++++
 tb/tb_wbp2classic.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbp2classic.sv
// wbp2classic: Wishbone pipelined-slave to Wishbone classic-master bridge.
//
// Takes one pipelined request at a time and replays it as a registered
// classic cycle. The slave's ack, err and read data are returned to the
// pipelined side. Dropping i_scyc aborts a cycle that is in flight. A bus
// error leaves the bridge stalled until the master drops i_scyc.
//
// Optional feature: define WBP2C_TIMEOUT_EN to add a watchdog. It turns a
// classic cycle that gets no answer into a bus error.
//
// Parameters:
//   AW        - word address width
//   DW        - data width (DW/8 byte selects)
//   LGTIMEOUT - watchdog counter width, must be >= 2 (WBP2C_TIMEOUT_EN only)
//
// Ports:
//   i_clk, i_reset       - clock, synchronous active-high reset
//   i_scyc, i_sstb       - pipelined cycle / strobe
//   i_swe, i_saddr,
//   i_sdata, i_ssel      - pipelined request fields
//   o_sstall             - stall; high whenever a request is outstanding
//   o_sack, o_serr       - one-cycle ack / error pulses
//   o_sdata              - read data, held until the next ack
//   o_mcyc, o_mstb       - classic cycle / strobe
//   o_mwe, o_maddr,
//   o_mdata, o_msel      - classic request fields, held for the whole cycle
//   o_mcti, o_mbte       - always classic single cycle (zero)
//   i_mack, i_merr       - classic ack / error
//   i_mdata              - classic read data
module wbp2classic #(
  parameter int unsigned AW        = 12,
  parameter int unsigned DW        = 32,
  parameter int unsigned LGTIMEOUT = 8
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_scyc,
  input  logic            i_sstb,
  input  logic            i_swe,
  input  logic [AW-1:0]   i_saddr,
  input  logic [DW-1:0]   i_sdata,
  input  logic [DW/8-1:0] i_ssel,
  output logic            o_sstall,
  output logic            o_sack,
  output logic [DW-1:0]   o_sdata,
  output logic            o_serr,
  output logic            o_mcyc,
  output logic            o_mstb,
  output logic            o_mwe,
  output logic [AW-1:0]   o_maddr,
  output logic [DW-1:0]   o_mdata,
  output logic [DW/8-1:0] o_msel,
  output logic [2:0]      o_mcti,
  output logic [1:0]      o_mbte,
  input  logic            i_mack,
  input  logic [DW-1:0]   i_mdata,
  input  logic            i_merr
);

  typedef enum logic [1:0] {StIdle, StBusy, StErrWait} state_e;

  state_e state;
  logic   expired;

`ifdef WBP2C_TIMEOUT_EN
  // The counter reads 0 in the first BUSY cycle. Expiry fires in the cycle
  // whose increment would make it all-ones. So a silent slave sees exactly
  // 2^LGTIMEOUT-1 BUSY cycles before the error.
  localparam logic [LGTIMEOUT-1:0] TimerLast = {{(LGTIMEOUT-1){1'b1}}, 1'b0};

  logic [LGTIMEOUT-1:0] timer;

  assign expired = (timer == TimerLast);
`else
  // No watchdog: BUSY waits for the slave indefinitely.
  assign expired = 1'b0;
`endif

  assign o_sstall = (state != StIdle);
  assign o_mcti   = 3'b000;
  assign o_mbte   = 2'b00;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= StIdle;
      o_mcyc  <= 1'b0;
      o_mstb  <= 1'b0;
      o_sack  <= 1'b0;
      o_serr  <= 1'b0;
      o_mwe   <= 1'b0;
      o_maddr <= '0;
      o_mdata <= '0;
      o_msel  <= '0;
      o_sdata <= '0;
`ifdef WBP2C_TIMEOUT_EN
      timer   <= '0;
`endif
    end else begin
      o_sack <= 1'b0;
      o_serr <= 1'b0;
      unique case (state)
        StIdle: begin
          if (i_scyc && i_sstb) begin
            o_mcyc  <= 1'b1;
            o_mstb  <= 1'b1;
            o_mwe   <= i_swe;
            o_maddr <= i_saddr;
            o_mdata <= i_sdata;
            o_msel  <= i_ssel;
            state   <= StBusy;
`ifdef WBP2C_TIMEOUT_EN
            timer   <= '0;
`endif
          end else if (!i_scyc) begin
            // Release the bus lock held over from the previous ack.
            o_mcyc <= 1'b0;
          end
        end
        StBusy: begin
`ifdef WBP2C_TIMEOUT_EN
          timer <= timer + 1'b1;
`endif
          if (!i_scyc) begin
            o_mcyc <= 1'b0;
            o_mstb <= 1'b0;
            state  <= StIdle;
          end else if (i_merr || (expired && !i_mack)) begin
            // A real ack beats the watchdog, but err beats ack.
            o_mcyc <= 1'b0;
            o_mstb <= 1'b0;
            o_serr <= 1'b1;
            state  <= StErrWait;
          end else if (i_mack) begin
            o_sdata <= i_mdata;
            o_sack  <= 1'b1;
            o_mstb  <= 1'b0;
            state   <= StIdle;
          end
        end
        StErrWait: begin
          o_mcyc <= 1'b0;
          if (!i_scyc) begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wbp2classic.sv
`timescale 1ns/1ps
module tb_wbp2classic;
  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int LGT = 4;
  localparam int KAck = 0, KErr = 1, KBoth = 2, KNone = 3;
`ifdef WBP2C_TIMEOUT_EN
  localparam bit TimeoutOn = 1'b1;
`else
  localparam bit TimeoutOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scyc = 1'b0, sstb = 1'b0, swe = 1'b0;
  logic [AW-1:0] saddr = '0;
  logic [DW-1:0] sdata = '0;
  logic [3:0] ssel = '0;
  logic sstall, sack, serr;
  logic [DW-1:0] sdata_o;
  logic mcyc, mstb, mwe;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mdata_o;
  logic [3:0] msel;
  logic [2:0] mcti;
  logic [1:0] mbte;
  logic mack = 1'b0, merr = 1'b0;
  logic [DW-1:0] mdata_i = '0;

  always #5 clk = ~clk;

  wbp2classic #(.AW(AW), .DW(DW), .LGTIMEOUT(LGT)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_scyc(scyc), .i_sstb(sstb), .i_swe(swe), .i_saddr(saddr), .i_sdata(sdata),
    .i_ssel(ssel), .o_sstall(sstall), .o_sack(sack), .o_sdata(sdata_o), .o_serr(serr),
    .o_mcyc(mcyc), .o_mstb(mstb), .o_mwe(mwe), .o_maddr(maddr), .o_mdata(mdata_o),
    .o_msel(msel), .o_mcti(mcti), .o_mbte(mbte), .i_mack(mack), .i_mdata(mdata_i),
    .i_merr(merr)
  );

  int checks = 0;
  int failures = 0;

  function automatic void chk(input string name, input bit ok, input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Expected pipelined-side responses, in order.
  typedef struct {
    bit          is_err;
    bit          chk_data;
    logic [31:0] data;
  } rsp_t;
  rsp_t sb[$];

  // Per-request behaviour of the classic slave model plus the request it must see.
  typedef struct {
    int          kind;
    int          lat;
    logic [31:0] rdata;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
  } scfg_t;
  scfg_t sq[$];

  int n_ack = 0, n_err = 0, mcyc_low = 0;
  int late_req = 0, late_seen = 0;

  // Classic slave model: answers each strobe after its configured wait states.
  int    wcnt = 0;
  bit    done = 0, active = 0, resp_prev = 0;
  scfg_t c_s;
  always @(posedge clk) begin
    #1;
    if (resp_prev) chk("no_stb_after_resp", !mstb, mstb, 0);
    resp_prev = 0;
    merr = 1'b0;
    mdata_i = $urandom;
    mack = (late_req != late_seen);
    late_seen = late_req;
    if (!mstb) begin
      if (active && sq.size() != 0) sq.delete(0);
      active = 0;
      wcnt = 0;
      done = 0;
    end else begin
      chk("stb_has_request", sq.size() != 0, sq.size(), 1);
      if (sq.size() != 0) begin
        c_s = sq[0];
        active = 1;
        chk("req_fields", {mwe, maddr, mdata_o, msel} === {c_s.we, c_s.addr, c_s.wdata, c_s.sel},
            {mwe, maddr, mdata_o, msel}, {c_s.we, c_s.addr, c_s.wdata, c_s.sel});
        chk("cti_bte_zero", {mcti, mbte} == 5'd0, {mcti, mbte}, 0);
        chk("cyc_with_stb", mcyc, mcyc, 1);
        if (!done) begin
          if (wcnt == c_s.lat) begin
            done = 1;
            resp_prev = 1;
            case (c_s.kind)
              KAck:  begin mack = 1'b1; mdata_i = c_s.rdata; end
              KErr:  merr = 1'b1;
              KBoth: begin mack = 1'b1; merr = 1'b1; end
              default: resp_prev = 0;
            endcase
          end else begin
            wcnt++;
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the bridge answers.
  rsp_t r_m;
  always @(negedge clk) begin
    if (!rst) begin
      if (!mcyc) mcyc_low++;
      if (sack || serr) begin
        chk("ack_err_exclusive", !(sack && serr), {sack, serr}, 0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_response: got sack=%0b serr=%0b, wanted none", sack, serr);
        end else begin
          r_m = sb.pop_front();
          chk("resp_kind", serr == r_m.is_err, serr, r_m.is_err);
          if (sack && r_m.chk_data) chk("read_data", sdata_o == r_m.data, sdata_o, r_m.data);
        end
        if (sack) n_ack++;
        if (serr) n_err++;
      end
    end
  end

  // Present one request and wait for acceptance; returns one cycle after the accepting edge.
  task automatic start_req(input logic we, input logic [11:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int kind, input int lat,
                           input logic [31:0] rd, input bit expect_rsp, output bit ok);
    scfg_t c;
    rsp_t  e;
    @(posedge clk);
    #2;
    c.kind = kind; c.lat = lat; c.rdata = rd; c.we = we; c.addr = a; c.wdata = d; c.sel = s;
    sq.push_back(c);
    scyc = 1'b1; sstb = 1'b1; swe = we; saddr = a; sdata = d; ssel = s;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (!sstall) ok = 1;
    end
    chk("accepted", ok, ok, 1);
    @(posedge clk);
    if (ok && expect_rsp) begin
      e.is_err = (kind != KAck);
      e.chk_data = (kind == KAck) && !we;
      e.data = rd;
      sb.push_back(e);
    end
    if (!ok) sq.delete(sq.size() - 1);
    #2;
    sstb = 1'b0; swe = $urandom; saddr = $urandom; sdata = $urandom; ssel = $urandom;
  endtask

  task automatic wait_sb(input int maxc);
    int i = 0;
    while (sb.size() != 0 && i < maxc) begin
      @(negedge clk);
      i++;
    end
    chk("response_arrived", sb.size() == 0, sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, wanted finish");
    $fatal(1);
  end

  int kind, lat, a0, e0, m0, nstb, busy;
  bit we, ok;
  logic [31:0] d;
  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {mcyc, mstb, sack, serr, sstall} == 5'd0, {mcyc, mstb, sack, serr, sstall}, 0);
    chk("reset_data", {mwe, maddr, mdata_o, msel, sdata_o} == '0, {mwe, maddr, mdata_o, msel}, 0);
    rst = 1'b0;

    // Read: slave acks one cycle after strobe.
    start_req(1'b0, 12'h040, 32'h0, 4'hF, KAck, 1, 32'hDEADBEEF, 1, ok);
    @(negedge clk);
    chk("rd_c1", {sstall, mstb, sack} == 3'b110, {sstall, mstb, sack}, 3'b110);
    @(negedge clk);
    chk("rd_c2", {sstall, mstb, sack} == 3'b110, {sstall, mstb, sack}, 3'b110);
    @(negedge clk);
    chk("rd_c3", {sstall, mstb, sack, mcyc} == 4'b0011, {sstall, mstb, sack, mcyc}, 4'b0011);
    chk("rd_data", sdata_o == 32'hDEADBEEF, sdata_o, 32'hDEADBEEF);
    scyc = 1'b0;
    @(negedge clk);
    chk("lock_release", !mcyc, mcyc, 0);

    // Write with three wait states.
    a0 = n_ack;
    start_req(1'b1, 12'h3A5, 32'h12345678, 4'b0011, KAck, 3, 32'h0, 1, ok);
    nstb = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mstb) nstb++;
      if (sack || serr) break;
    end
    chk("wr_stb_cycles", nstb == 4, nstb, 4);
    repeat (3) @(negedge clk);
    chk("wr_single_ack", n_ack == a0 + 1, n_ack - a0, 1);
    scyc = 1'b0;

    // Back-to-back with the cycle held.
    a0 = n_ack;
    start_req(1'b0, 12'h011, 32'h0, 4'hF, KAck, 0, 32'hA5A55A5A, 1, ok);
    m0 = mcyc_low;
    start_req(1'b0, 12'h022, 32'h0, 4'hF, KAck, 2, 32'h0BADF00D, 1, ok);
    chk("b2b_order", n_ack == a0 + 1, n_ack - a0, 1);
    wait_sb(20);
    repeat (2) @(negedge clk);
    chk("b2b_two_acks", n_ack == a0 + 2, n_ack - a0, 2);
    chk("b2b_cyc_held", mcyc_low == m0, mcyc_low - m0, 0);
    scyc = 1'b0;

    // Error and ack together: error wins, bridge waits for cycle drop.
    a0 = n_ack;
    e0 = n_err;
    start_req(1'b0, 12'h0F0, 32'h0, 4'hF, KBoth, 1, 32'h0, 1, ok);
    wait_sb(20);
    chk("err_cyc_low", !mcyc, mcyc, 0);
    sstb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("errwait_stall", {sstall, mcyc, mstb} == 3'b100, {sstall, mcyc, mstb}, 3'b100);
    end
    chk("err_counts", (n_err == e0 + 1) && (n_ack == a0), {n_err - e0, n_ack - a0}, {32'd1, 32'd0});
    scyc = 1'b0;
    sstb = 1'b0;
    @(negedge clk);
    chk("errwait_exit", !sstall, sstall, 0);
    start_req(1'b0, 12'h0F1, 32'h0, 4'hF, KAck, 0, 32'h13579BDF, 1, ok);
    wait_sb(20);
    scyc = 1'b0;

    // Abort followed by a late ack.
    a0 = n_ack;
    start_req(1'b0, 12'h100, 32'h0, 4'hF, KAck, 10, 32'h0, 0, ok);
    @(negedge clk);
    scyc = 1'b0;
    late_req++;
    @(negedge clk);
    chk("abort_drop", {mcyc, mstb, sack} == 3'b000, {mcyc, mstb, sack}, 0);
    @(negedge clk);
    chk("abort_no_ack", {sack, sstall} == 2'b00 && n_ack == a0, {sack, sstall}, 0);

    // Reset in the middle of a cycle.
    start_req(1'b1, 12'h200, 32'hCAFEF00D, 4'hC, KAck, 10, 32'h0, 0, ok);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ctrl", {mcyc, mstb, sack, serr, sstall} == 5'd0, {mcyc, mstb, sack, serr, sstall}, 0);
    chk("rst_mid_data", {mwe, maddr, mdata_o, msel, sdata_o} == '0, {mwe, maddr, mdata_o, msel}, 0);
    scyc = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Silent slave.
    e0 = n_err;
    start_req(1'b0, 12'h300, 32'h0, 4'hF, KNone, 0, 32'h0, TimeoutOn, ok);
    if (TimeoutOn) begin
      busy = 0;
      for (int i = 0; i < (1 << LGT) + 8; i++) begin
        @(negedge clk);
        if (serr) break;
        busy++;
      end
      chk("timeout_cycles", busy == (1 << LGT) - 1, busy, (1 << LGT) - 1);
    end else begin
      repeat (100) @(negedge clk);
      chk("no_timeout", n_err == e0 && mstb, {n_err - e0, 31'd0, mstb}, 1);
    end
    scyc = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Randomised traffic.
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 2);
      lat = $urandom_range(0, 5);
      we = $urandom;
      d = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        start_req(we, 12'($urandom), $urandom, 4'($urandom), KAck, 12, d, 0, ok);
        repeat ($urandom_range(1, 3)) @(negedge clk);
        scyc = 1'b0;
        @(negedge clk);
        chk("rand_abort", {mcyc, mstb} == 2'b00, {mcyc, mstb}, 0);
      end else begin
        start_req(we, 12'($urandom), $urandom, 4'($urandom), kind, lat, d, 1, ok);
        wait_sb(20);
        if (kind != KAck || $urandom_range(0, 1) == 1) begin
          scyc = 1'b0;
          @(negedge clk);
        end
      end
    end
    scyc = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size() == 0, sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
